// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset/lock sequencer.
// Pure definitions; no latency and no backpressure.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    REL_OP,
    REL_OS,
    REL_OS2,
    RUN,
    FAIL
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock, cleared to 0 by synchronous reset.
// Latency: two clk edges from d to q; no backpressure.
module pll_seq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset pulse, qualified lock with timeout/retry, then ordered CLKOP/CLKOS/CLKOS2 reset release; LOSS_CNT built only with PLL_SEQ_LOSS_CNT_EN.
// Outputs registered from the next state (one edge after the FSM decides); no backpressure, inputs are level/pulse only.
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int REL_GAP_CYC      = 8,
  parameter int MAX_RETRY        = 7
) (
  input  logic                  CLKI,
  input  logic                  RST,
  input  logic                  LOCK,
  input  logic                  RESTART,
  output logic                  PLL_RST,
  output logic                  RST_OP,
  output logic                  RST_OS,
  output logic                  RST_OS2,
  output logic                  READY,
  output logic                  LOCK_FAIL,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

  localparam int MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_B   = (LOCK_STABLE_CYC > REL_GAP_CYC) ? LOCK_STABLE_CYC : REL_GAP_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = cnt_w(CNT_MAX);
  localparam int RETRY_W = cnt_w(MAX_RETRY);

  // Terminal values are one less than the length: the entry cycle counts as cycle 0.
  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(REL_GAP_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LIM    = RETRY_W'(MAX_RETRY);

  seq_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               lock_s;
  logic               restart_q;
  logic               cnt_clr;
  logic               cnt_run;

  pll_seq_sync2 u_lock_sync (
    .clk (CLKI),
    .rst (RST),
    .d   (LOCK),
    .q   (lock_s)
  );

  // RESTART is registered so it is judged in the same cycle as lock_s/timeouts it must override.
  always_ff @(posedge CLKI) begin
    if (RST) restart_q <= 1'b0;
    else     restart_q <= RESTART;
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    if (restart_q) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = (retry_nxt == RETRY_LIM) ? FAIL : RESET_PLL;
          end
        end
        STABLE: begin
          if (!lock_s)                 state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = REL_OP;
        end
        REL_OP: begin
          if (!lock_s)              state_nxt = RESET_PLL;
          else if (cnt == GAP_LAST) state_nxt = REL_OS;
        end
        REL_OS: begin
          if (!lock_s)              state_nxt = RESET_PLL;
          else if (cnt == GAP_LAST) state_nxt = REL_OS2;
        end
        REL_OS2: begin
          if (!lock_s) begin
            state_nxt = RESET_PLL;
          end else if (cnt == GAP_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!lock_s) state_nxt = RESET_PLL;
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = RESET_PLL;
        end
      endcase
    end
  end

  // A RESTART while already in RESET_PLL is still a fresh entry, so the pulse restarts.
  assign cnt_clr = restart_q || (state_nxt != state);
  assign cnt_run = (state != RUN) && (state != FAIL) && (cnt != CNT_SAT);

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_run) cnt <= cnt + CNT_W'(1);
    end
  end

  // Each domain reset is low only in the states at or past its release point.
  always_ff @(posedge CLKI) begin
    if (RST) begin
      PLL_RST   <= 1'b1;
      RST_OP    <= 1'b1;
      RST_OS    <= 1'b1;
      RST_OS2   <= 1'b1;
      READY     <= 1'b0;
      LOCK_FAIL <= 1'b0;
    end else begin
      PLL_RST   <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      RST_OP    <= !(state_nxt inside {REL_OP, REL_OS, REL_OS2, RUN});
      RST_OS    <= !(state_nxt inside {REL_OS, REL_OS2, RUN});
      RST_OS2   <= !(state_nxt inside {REL_OS2, RUN});
      READY     <= (state_nxt == RUN);
      LOCK_FAIL <= (state_nxt == FAIL);
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic loss_evt;

  assign loss_evt = !restart_q && !lock_s && (state inside {REL_OP, REL_OS, REL_OS2, RUN});

  always_ff @(posedge CLKI) begin
    if (RST)                          LOSS_CNT <= '0;
    else if (loss_evt && LOSS_CNT != '1) LOSS_CNT <= LOSS_CNT + LOSS_CNT_W'(1);
  end
`else
  assign LOSS_CNT = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed-plus-random bench for pll_rst_seq: edge-count timing expectations derived from the parameters,
// with a lock-loss count model that follows the PLL_SEQ_LOSS_CNT_EN build.
module tb_pll_rst_seq;

  localparam int P_PULSE = 4;
  localparam int P_TO    = 100;
  localparam int P_STAB  = 10;
  localparam int P_GAP   = 2;
  localparam int P_RETRY = 2;
  localparam int OP_DLY  = 2 + P_STAB + 1;

  logic       CLKI = 1'b0;
  logic       RST;
  logic       LOCK;
  logic       RESTART;
  logic       PLL_RST;
  logic       RST_OP;
  logic       RST_OS;
  logic       RST_OS2;
  logic       READY;
  logic       LOCK_FAIL;
  logic [7:0] LOSS_CNT;

  int n_cmp = 0;
  int n_bad = 0;
  int loss_model = 0;

  pll_rst_seq #(
    .RST_PULSE_CYC    (P_PULSE),
    .LOCK_TIMEOUT_CYC (P_TO),
    .LOCK_STABLE_CYC  (P_STAB),
    .REL_GAP_CYC      (P_GAP),
    .MAX_RETRY        (P_RETRY)
  ) dut (
    .CLKI      (CLKI),
    .RST       (RST),
    .LOCK      (LOCK),
    .RESTART   (RESTART),
    .PLL_RST   (PLL_RST),
    .RST_OP    (RST_OP),
    .RST_OS    (RST_OS),
    .RST_OS2   (RST_OS2),
    .READY     (READY),
    .LOCK_FAIL (LOCK_FAIL),
    .LOSS_CNT  (LOSS_CNT)
  );

  always #5 CLKI = ~CLKI;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  // {PLL_RST, RST_OP, RST_OS, RST_OS2, READY, LOCK_FAIL}
  localparam logic [5:0] V_RESET = 6'b111100;
  localparam logic [5:0] V_RUN   = 6'b000010;
  localparam logic [5:0] V_WAIT  = 6'b011100;
  localparam logic [5:0] V_FAIL  = 6'b111101;

  function automatic logic [5:0] outs();
    return {PLL_RST, RST_OP, RST_OS, RST_OS2, READY, LOCK_FAIL};
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0:       return PLL_RST;
      1:       return RST_OP;
      2:       return RST_OS;
      3:       return RST_OS2;
      4:       return READY;
      default: return LOCK_FAIL;
    endcase
  endfunction

  function automatic int exp_loss();
`ifdef PLL_SEQ_LOSS_CNT_EN
    return (loss_model > 255) ? 255 : loss_model;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLKI);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, outs()}, {26'd0, exp});
  endtask

  task automatic chk_loss(input string tag);
    chk(tag, {24'd0, LOSS_CNT}, exp_loss());
  endtask

  // Edges until output w takes value v; -1 if the budget runs out.
  task automatic wait_val(input int w, input logic v, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (sig(w) === v) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic expect_edge(input string tag, input int w, input logic v, input int exp);
    int n;
    wait_val(w, v, 400, n);
    chk(tag, n, exp);
  endtask

  task automatic release_seq(input string tag, input int exp_op, input bit full);
    expect_edge({tag, "_op"}, 1, 1'b0, exp_op);
    if (full) begin
      expect_edge({tag, "_os"}, 2, 1'b0, P_GAP);
      expect_edge({tag, "_os2"}, 3, 1'b0, P_GAP);
      expect_edge({tag, "_ready"}, 4, 1'b1, P_GAP);
      chk_vec({tag, "_run"}, V_RUN);
    end
  endtask

  task automatic lock_and_release(input string tag, input int d);
    tick(d);
    LOCK = 1'b1;
    release_seq(tag, OP_DLY, 1'b1);
  endtask

  task automatic lose_lock(input string tag, input bit in_run);
    LOCK = 1'b0;
    tick(2);
    if (in_run) chk_vec({tag, "_hold"}, V_RUN);
    tick(1);
    loss_model++;
    chk_vec({tag, "_rst"}, V_RESET);
    chk_loss({tag, "_loss"});
  endtask

  task automatic pulse_restart();
    RESTART = 1'b1;
    tick(1);
    RESTART = 1'b0;
  endtask

  task automatic run_to_fail(input string tag);
    expect_edge({tag, "_pll_fall1"}, 0, 1'b0, P_PULSE);
    expect_edge({tag, "_timeout1"}, 0, 1'b1, P_TO);
    expect_edge({tag, "_pll_fall2"}, 0, 1'b0, P_PULSE);
    expect_edge({tag, "_timeout2"}, 5, 1'b1, P_TO);
    chk_vec({tag, "_fail"}, V_FAIL);
  endtask

  initial begin
    int h, l;
    RST     = 1'b1;
    LOCK    = 1'b0;
    RESTART = 1'b0;
    tick(5);
    chk_vec("por_vals", V_RESET);
    chk_loss("por_loss");

    // Nominal bring-up with a random lock delay.
    RST = 1'b0;
    expect_edge("por_pll_fall", 0, 1'b0, P_PULSE);
    lock_and_release("bringup", $urandom_range(0, 90));

    // Lock loss in RUN, then a full re-run.
    lose_lock("loss_run", 1'b1);
    expect_edge("loss_pll_fall", 0, 1'b0, P_PULSE);
    lock_and_release("loss_rerun", $urandom_range(0, 90));

    // RESTART sampled so it lands on the same FSM cycle as the lock loss.
    LOCK = 1'b0;
    tick(1);
    pulse_restart();
    tick(1);
    chk_vec("rs_loss_rst", V_RESET);
    chk_loss("rs_loss_cnt");
    expect_edge("rs_loss_pll_fall", 0, 1'b0, P_PULSE);
    lock_and_release("rs_loss_rerun", $urandom_range(0, 90));

    // Glitchy lock while qualifying: stable count must restart from the re-lock.
    lose_lock("glitch_pre", 1'b1);
    expect_edge("glitch_pll_fall", 0, 1'b0, P_PULSE);
    h = $urandom_range(1, 8);
    l = $urandom_range(1, 4);
    LOCK = 1'b1;
    tick(h);
    LOCK = 1'b0;
    tick(l);
    chk_vec("glitch_held", V_WAIT);
    LOCK = 1'b1;
    release_seq("glitch_relock", OP_DLY, 1'b1);

    // Lock never returns: retry once, then FAIL; FAIL ignores a later lock.
    lose_lock("nolock_pre", 1'b1);
    run_to_fail("nolock");
    LOCK = 1'b1;
    tick(20);
    chk_vec("fail_sticky", V_FAIL);
    chk_loss("fail_loss");

    // RESTART out of FAIL with lock still absent: retries are fresh again.
    LOCK = 1'b0;
    tick(5);
    pulse_restart();
    chk_vec("rs_fail_edge_n", V_FAIL);
    tick(1);
    chk_vec("rs_fail_edge_n1", V_RESET);
    run_to_fail("rs_fail_retry");

    // RESTART out of FAIL with lock already present.
    LOCK = 1'b1;
    tick(5);
    pulse_restart();
    tick(1);
    chk_vec("rs_fail_locked", V_RESET);
    expect_edge("rs_locked_pll_fall", 0, 1'b0, P_PULSE);
    release_seq("rs_locked", P_STAB + 1, 1'b1);
    chk_loss("rs_locked_loss");

    // Repeated losses push LOSS_CNT past saturation.
    for (int i = 0; i < 300; i++) begin
      lose_lock("sat", 1'b0);
      expect_edge("sat_pll_fall", 0, 1'b0, P_PULSE);
      tick($urandom_range(0, 5));
      LOCK = 1'b1;
      release_seq("sat", OP_DLY, 1'b0);
    end
    chk_loss("sat_final");

    // Mid-sequence RST behaves like power-up.
    RST = 1'b1;
    tick(1);
    loss_model = 0;
    chk_vec("mid_rst_vals", V_RESET);
    chk_loss("mid_rst_loss");
    RST = 1'b0;
    expect_edge("mid_rst_pll_fall", 0, 1'b0, P_PULSE);
    release_seq("mid_rst", P_STAB + 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
